fxp_requant: RTL and testbench
==============================

Name: fxp_requant

Overview:
Downstream stage of the fixed-point adder (fp_add). Takes the adder's signed two's-complement sum and its overflow flag. Converts the sum to a narrower output Q-format with round-half-up and saturation. Two-stage pipeline with valid/ready handshakes and a saturating event counter.

Parameters:
N_IN, 6, input integer bits (sign included)
M_IN, 12, input fraction bits
N_OUT, 4, output integer bits (sign included), N_OUT >= 1
M_OUT, 8, output fraction bits
CNT_W, 16, width of sat_count

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept an input this cycle
in_data  in  N_IN+M_IN  signed sum from adder, Q(N_IN).(M_IN)
in_ovf  in  1  adder overflow flag for in_data
out_valid  out  1  output sample valid
out_ready  in  1  consumer accepts output
out_data  out  N_OUT+M_OUT  signed requantized result, Q(N_OUT).(M_OUT)
out_sat  out  1  out_data was clamped (saturation or in_ovf)
clr_count  in  1  synchronous clear of sat_count
sat_count  out  CNT_W  number of saturated outputs delivered

Behaviour:
- Reset (rst=1 at clock edge):
  - s1_valid=0, out_valid=0, out_data=0, out_sat=0, sat_count=0.
  - in_ready=1 in the first cycle after reset.
  - Any in-flight samples are discarded.
- Handshake and flow control:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - adv = !out_valid || out_ready.
  - in_ready = !s1_valid || adv. This is combinational from registers and out_ready only, not from in_valid.
  - Stage 1 loads on an input transfer. Otherwise it clears s1_valid when stage 2 takes its sample (s1_valid&&adv).
  - Stage 2 (output regs) loads from stage 1 when adv. out_valid <= s1_valid.
  - While out_valid&&!out_ready, out_data and out_sat are held stable.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid, with out_ready held high.
  - Throughput is 1 sample/cycle.
  - No sample is lost or duplicated under any backpressure pattern.
- Stage 1, fraction alignment; result kept at N_IN+M_OUT+1 signed bits:
  - M_OUT<M_IN: d=M_IN-M_OUT. Add 2^(d-1) to the sign-extended input, then arithmetic shift right by d.
  - M_OUT>=M_IN: left shift by M_OUT-M_IN, zero fill.
  - in_ovf is registered alongside the data.
- Stage 2, integer saturation:
  - MAX=0111..1, MIN=1000..0 (N_OUT+M_OUT bits).
  - If ovf: out_data=MAX when the original in_data MSB was 1 (wrapped positive), else MIN. out_sat=1.
  - Else if the aligned value > MAX: out_data=MAX, out_sat=1.
  - Else if the aligned value < MIN: out_data=MIN, out_sat=1.
  - Else out_data is the aligned value truncated to width, out_sat=0.
  - Rounding carry into overflow saturates; it does not wrap.
- sat_count:
  - Increments on each output transfer with out_sat=1.
  - Sticks at all-ones and never wraps.
  - clr_count has priority over a simultaneous increment (result 0).
  - rst clears it.

Optional Feature:
Macro FXP_REQUANT_CONVERGENT_EN.
- Defined: stage 1 rounds half-to-even. An exact tie (discarded bits = 100..0) rounds toward the even retained LSB; non-ties round to nearest as before.
- Undefined: round-half-up as specified above.
- Latency, handshake and saturation are unchanged in both builds.

Test Plan:
- Defaults, in_data=111101_110000000000 (-2.25), in_ovf=0, out_ready=1 -> two cycles later out_data=12'hDC0, out_sat=0, sat_count=0.
- Rounding tie: in_data=000001_100000001000 (1.5+2^-9):
  - Default build -> out_data=12'h181.
  - FXP_REQUANT_CONVERGENT_EN build -> 12'h180.
- Saturation:
  - in_data=001010_000000000000 (+10) -> 12'h7FF, out_sat=1.
  - -9.0 -> 12'h800, out_sat=1.
  - 000111_111111111000 (round to 8.0) -> 12'h7FF, out_sat=1.
  - Afterwards sat_count=3.
- Overflow forcing:
  - in_ovf=1 with in_data=100000_000000000000 -> 12'h7FF.
  - in_ovf=1 with in_data=011111_111111111111 -> 12'h800.
  - Both give out_sat=1.
- Backpressure: stream 8 samples back-to-back with out_ready toggling pseudo-randomly -> all 8 delivered in order, no change of out_data while stalled, in_ready=0 only when both stages are full and out_ready=0.
- Reset mid-stream with both stages full, plus clr_count asserted concurrently with a saturated transfer:
  - After the reset edge: out_valid=0, in_ready=1, sat_count=0.
  - clr_count with a simultaneous saturated transfer gives sat_count=0.

Source files
------------

// File: rtl/fxp_requant.sv
// Requantizer for fp_add sums: two-stage valid/ready pipeline that rounds and saturates to Q(N_OUT).(M_OUT).
// Optional build macro FXP_REQUANT_CONVERGENT_EN selects round-half-to-even instead of round-half-up.
module fxp_requant #(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned M_IN  = 12,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned M_OUT = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN+M_IN-1:0]   in_data,
  input  logic                   in_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT+M_OUT-1:0] out_data,
  output logic                   out_sat,
  input  logic                   clr_count,
  output logic [CNT_W-1:0]       sat_count
);

  localparam int unsigned IW = N_IN + M_IN;
  localparam int unsigned AW = N_IN + M_OUT + 1;
  localparam int unsigned OW = N_OUT + M_OUT;
  localparam int unsigned CW = (AW > OW) ? AW : OW;

  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [OW-1:0]        OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0]        OUT_MIN = {1'b1, {(OW-1){1'b0}}};

  logic signed [AW-1:0] align;

  generate
    if (M_OUT < M_IN) begin : g_round
      localparam int unsigned D = M_IN - M_OUT;
      logic signed [IW:0] ext;
      logic signed [IW:0] bias;
      assign ext = {in_data[IW-1], in_data};
`ifdef FXP_REQUANT_CONVERGENT_EN
      // Half-minus-one plus the retained LSB: exact ties land on the even neighbour.
      assign bias = ((IW+1)'(1) << (D-1)) - (IW+1)'(1) + (IW+1)'(in_data[D]);
`else
      assign bias = (IW+1)'(1) << (D-1);
`endif
      // One guard bit above the input keeps the rounding carry from wrapping.
      assign align = AW'((ext + bias) >>> D);
    end else begin : g_shift
      logic signed [AW-1:0] ext;
      assign ext   = {{(AW-IW){in_data[IW-1]}}, in_data};
      assign align = ext <<< (M_OUT - M_IN);
    end
  endgenerate

  logic                 s1_valid;
  logic signed [AW-1:0] s1_align;
  logic                 s1_ovf;
  logic                 s1_msb;
  logic                 adv;
  logic                 in_xfer;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_align <= '0;
      s1_ovf   <= 1'b0;
      s1_msb   <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_align <= align;
      s1_ovf   <= in_ovf;
      s1_msb   <= in_data[IW-1];
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  logic signed [CW-1:0] a_ext;
  logic [OW-1:0]        sat_data;
  logic                 sat_flag;

  assign a_ext = CW'(s1_align);

  always_comb begin
    sat_data = a_ext[OW-1:0];
    sat_flag = 1'b0;
    if (s1_ovf) begin
      // A set MSB on an overflowed sum means the true result wrapped from positive.
      sat_data = s1_msb ? OUT_MAX : OUT_MIN;
      sat_flag = 1'b1;
    end else if (a_ext > SAT_MAX) begin
      sat_data = OUT_MAX;
      sat_flag = 1'b1;
    end else if (a_ext < SAT_MIN) begin
      sat_data = OUT_MIN;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_data;
        out_sat  <= sat_flag;
      end
    end
  end

  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      sat_count <= '0;
    end else if (out_xfer && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fxp_requant.sv
// Bench for fxp_requant: directed vector table, handshake corner sequences and a randomized
// stream scored against a real-arithmetic model of the rounding and saturation rules.
module tb_fxp_requant;

  localparam int unsigned N_IN  = 6;
  localparam int unsigned M_IN  = 12;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned M_OUT = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IW    = N_IN + M_IN;
  localparam int unsigned OW    = N_OUT + M_OUT;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     in_data;
  logic              in_ovf;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic              out_sat;
  logic              clr_count;
  logic [CNT_W-1:0]  sat_count;

  always #5 clk = ~clk;

  fxp_requant #(
    .N_IN (N_IN),
    .M_IN (M_IN),
    .N_OUT(N_OUT),
    .M_OUT(M_OUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ovf   (in_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .clr_count(clr_count),
    .sat_count(sat_count)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          sat;
  } exp_t;

  typedef struct {
    logic [IW-1:0] d;
    logic          ovf;
    logic [OW-1:0] q;
    logic          s;
  } vec_t;

  int          checks    = 0;
  int          errors    = 0;
  int          delivered = 0;
  exp_t        sb[$];
  int unsigned sc_model  = 0;
  logic        stall_q   = 1'b0;
  logic [OW-1:0] stall_data;
  logic        stall_sat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value in output LSB units, rounded per build, then clamped to the output range.
  function automatic exp_t model(input logic [IW-1:0] d, input logic ovf);
    real    r, fl;
    longint q, maxv, minv;
    exp_t   e;
    maxv = (longint'(1) << (OW-1)) - 1;
    minv = -(longint'(1) << (OW-1));
    r  = real'($signed(d)) * (2.0 ** (real'(M_OUT) - real'(M_IN)));
    fl = $floor(r);
    if (r - fl > 0.5)      q = longint'(fl) + 1;
    else if (r - fl < 0.5) q = longint'(fl);
    else begin
`ifdef FXP_REQUANT_CONVERGENT_EN
      q = (longint'(fl) % 2 == 0) ? longint'(fl) : longint'(fl) + 1;
`else
      q = longint'(fl) + 1;
`endif
    end
    if (ovf) begin
      e.data = d[IW-1] ? OW'(maxv) : OW'(minv);
      e.sat  = 1'b1;
    end else if (q > maxv) begin
      e.data = OW'(maxv);
      e.sat  = 1'b1;
    end else if (q < minv) begin
      e.data = OW'(minv);
      e.sat  = 1'b1;
    end else begin
      e.data = OW'(q);
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard and protocol monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic xfer_sat;
    if (rst) begin
      sb.delete();
      sc_model = 0;
      stall_q  = 1'b0;
    end else begin
      check("sat_count", sat_count, sc_model);
      check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      if (stall_q) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, stall_data);
        check("stall_sat", out_sat, stall_sat);
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_sat  = out_sat;
      xfer_sat   = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got data %0h with no sample pending, expected none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_sat !== e.sat) begin
            errors++;
            $display("FAIL stream_out: got %0h/%0b, expected %0h/%0b", out_data, out_sat,
                     e.data, e.sat);
          end
          xfer_sat = e.sat;
          delivered++;
        end
      end
      if (clr_count) sc_model = 0;
      else if (xfer_sat && sc_model < (1 << CNT_W) - 1) sc_model++;
      if (in_valid && in_ready) sb.push_back(model(in_data, in_ovf));
    end
  end

  task automatic send_one(input logic [IW-1:0] d, input logic ovf,
                          output logic [OW-1:0] q, output logic s);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_ovf    = ovf;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_early", out_valid, 1'b0);
    @(negedge clk);
    check("latency", out_valid, 1'b1);
    q = out_data;
    s = out_sat;
  endtask

  function automatic logic [IW-1:0] rand_data();
    int v;
    unique case ($urandom_range(3))
      0: return IW'($urandom);
      1: begin
        v = int'($urandom_range(65535)) - 32768;
        return IW'(v);
      end
      2: return IW'(($urandom & 32'hFFFF_FFF0) | 32'h8);
      default: begin
        v = int'($urandom_range(64)) - 32;
        return ($urandom_range(1) == 1) ? IW'(32752 + v) : IW'(-32768 + v);
      end
    endcase
  endfunction

  task automatic stream(input int n, input int vprob, input int rprob);
    int   sent  = 0;
    int   guard = 0;
    logic hold  = 1'b0;
    while (sent < n && guard < 4000) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < rprob);
      if (!hold) begin
        in_valid = ($urandom_range(99) < vprob);
        in_data  = rand_data();
        in_ovf   = ($urandom_range(9) == 0);
      end
      @(negedge clk);
      hold = in_valid && !in_ready;
      if (in_valid && in_ready) sent++;
      guard++;
    end
    check("stream_sent", sent, n);
  endtask

  task automatic drain();
    int guard = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    vec_t          vecs[15];
    logic [OW-1:0] q;
    logic          s;
    int            base;

    vecs[0]  = '{18'h3DC00, 1'b0, 12'hDC0, 1'b0};
`ifdef FXP_REQUANT_CONVERGENT_EN
    vecs[1]  = '{18'h01808, 1'b0, 12'h180, 1'b0};
`else
    vecs[1]  = '{18'h01808, 1'b0, 12'h181, 1'b0};
`endif
    vecs[2]  = '{18'h0A000, 1'b0, 12'h7FF, 1'b1};
    vecs[3]  = '{18'h37000, 1'b0, 12'h800, 1'b1};
    vecs[4]  = '{18'h07FF8, 1'b0, 12'h7FF, 1'b1};
    vecs[5]  = '{18'h20000, 1'b1, 12'h7FF, 1'b1};
    vecs[6]  = '{18'h1FFFF, 1'b1, 12'h800, 1'b1};
    vecs[7]  = '{18'h00000, 1'b0, 12'h000, 1'b0};
    vecs[8]  = '{18'h3FFFF, 1'b0, 12'h000, 1'b0};
    vecs[9]  = '{18'h3FFF7, 1'b0, 12'hFFF, 1'b0};
    vecs[10] = '{18'h07FF0, 1'b0, 12'h7FF, 1'b0};
    vecs[11] = '{18'h38000, 1'b0, 12'h800, 1'b0};
`ifdef FXP_REQUANT_CONVERGENT_EN
    vecs[12] = '{18'h00008, 1'b0, 12'h000, 1'b0};
`else
    vecs[12] = '{18'h00008, 1'b0, 12'h001, 1'b0};
`endif
    vecs[13] = '{18'h37FF7, 1'b0, 12'h800, 1'b1};
    vecs[14] = '{18'h3FFF8, 1'b0, 12'h000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ovf    = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 12'h000);
    check("rst_out_sat", out_sat, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sat_count", sat_count, 0);

    for (int i = 0; i < 15; i++) begin
      send_one(vecs[i].d, vecs[i].ovf, q, s);
      check($sformatf("vec%0d_data", i), q, vecs[i].q);
      check($sformatf("vec%0d_sat", i), s, vecs[i].s);
      if (i == 4) begin
        @(negedge clk);
        check("sat_count_after_3", sat_count, 3);
      end
    end

    // Counter must stick at all-ones.
    for (int i = 0; i < 20; i++) send_one(18'h0A000, 1'b0, q, s);
    @(negedge clk);
    check("sat_count_sticky", sat_count, 4'hF);

    // Clear coincides with a saturated output transfer.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 18'h0A000;
    in_ovf   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr_count = 1'b1;
    @(negedge clk);
    check("clr_sat_pending", out_sat, 1'b1);
    @(posedge clk); #1;
    clr_count = 1'b0;
    @(negedge clk);
    check("clr_priority", sat_count, 0);

    base = delivered;
    stream(8, 100, 50);
    drain();
    check("bp_delivered", delivered - base, 8);

    base = delivered;
    stream(150, 70, 60);
    stream(150, 90, 30);
    drain();
    check("rand_delivered", delivered - base, 300);

    // Fill both stages under backpressure, then reset.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 18'h0A000;
    in_ovf    = 1'b0;
    @(posedge clk); #1;
    in_data = 18'h37000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_sat_count", sat_count, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_output", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
